// File: rtl/demux_1x4_reg.sv
// Registered 1-to-4 demultiplexer with a one-entry valid/ready holding register per channel.
// Optional feature: define DEMUX_AUTO_SEL_EN to deal words round-robin and ignore select.
module demux_1x4_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] out_0,
    output logic [WIDTH-1:0] out_1,
    output logic [WIDTH-1:0] out_2,
    output logic [WIDTH-1:0] out_3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       cur_sel
);

    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic             accept;

`ifdef DEMUX_AUTO_SEL_EN
    logic [1:0] rr_ptr_q;
    logic [1:0] rr_ptr_d;

    assign cur_sel = rr_ptr_q;

    // The pointer only advances on accept, so a stalled channel blocks the input rather than being skipped.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = rr_ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            rr_ptr_q <= 2'b00;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign cur_sel = select;
`endif

    assign in_ready = ~valid_q[cur_sel] | out_ready[cur_sel];
    assign accept   = in_valid & in_ready;

    // A load to a channel wins over its drain, which keeps full throughput on one channel.
    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < 4; k++) begin
            data_d[k] = data_q[k];
            if (valid_q[k] && out_ready[k]) begin
                valid_d[k] = 1'b0;
            end
            if (accept && (cur_sel == 2'(k))) begin
                valid_d[k] = 1'b1;
                data_d[k]  = in_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            valid_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_0     = data_q[0];
    assign out_1     = data_q[1];
    assign out_2     = data_q[2];
    assign out_3     = data_q[3];
    assign out_valid = valid_q;

endmodule

// File: tb/tb_demux_1x4_reg.sv
// Directed-vector bench for demux_1x4_reg; expected values are hand-computed constants.
// Round-robin vectors run only when DEMUX_AUTO_SEL_EN is defined.
module tb_demux_1x4_reg;

    logic       clock;
    logic       reset_b;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] select;
    logic [7:0] out_0;
    logic [7:0] out_1;
    logic [7:0] out_2;
    logic [7:0] out_3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] cur_sel;

    int vectors;
    int miscompares;

    demux_1x4_reg #(.WIDTH(8)) dut (
        .clock     (clock),
        .reset_b   (reset_b),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .select    (select),
        .out_0     (out_0),
        .out_1     (out_1),
        .out_2     (out_2),
        .out_3     (out_3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cur_sel   (cur_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] sel, input logic [7:0] d,
                                 input logic [3:0] rdy);
        in_valid  = v;
        select    = sel;
        in_data   = d;
        out_ready = rdy;
    endtask

    // Advance to just after the next rising edge so registered outputs are settled.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] chan(input int k);
        case (k)
            0:       return out_0;
            1:       return out_1;
            2:       return out_2;
            default: return out_3;
        endcase
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_b     = 1'b0;
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);

        #3;
        checkOutput("reset_valid", out_valid, 4'b0000);
        checkOutput("reset_out0", out_0, 8'h00);
        checkOutput("reset_out3", out_3, 8'h00);
        #4;
        reset_b = 1'b1;
        step();

`ifndef DEMUX_AUTO_SEL_EN
        // Routing: one word per channel with all consumers stalled.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'(i), 8'hA0 + 8'(i), 4'b0000);
            #1;
            checkOutput("route_ready", in_ready, 1);
            checkOutput("route_cursel", cur_sel, i);
            step();
            checkOutput("route_data", chan(i), 8'hA0 + 8'(i));
            checkOutput("route_vbit", out_valid[i], 1);
        end
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
        #1;
        checkOutput("route_all_valid", out_valid, 4'b1111);

        // Drain channels 0 and 2, then assert reset mid-run with out_valid=1010.
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b0101);
        step();
        checkOutput("drain_02_valid", out_valid, 4'b1010);
        checkOutput("drain_keeps_data", out_0, 8'hA0);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
        reset_b = 1'b0;
        #1;
        checkOutput("async_rst_valid", out_valid, 4'b0000);
        checkOutput("async_rst_out1", out_1, 8'h00);
        checkOutput("async_rst_out3", out_3, 8'h00);
        for (int s = 0; s < 4; s++) begin
            select = 2'(s);
            #1;
            checkOutput("rst_in_ready", in_ready, 1);
        end
        reset_b = 1'b1;
        step();

        // Backpressure on channel 2, then accept on channel 1.
        applyStimulus(1'b1, 2'd2, 8'h55, 4'b0000);
        step();
        checkOutput("bp_load2", out_valid, 4'b0100);
        applyStimulus(1'b1, 2'd2, 8'h66, 4'b0000);
        #1;
        checkOutput("bp_in_ready", in_ready, 0);
        step();
        checkOutput("bp_out2_held", out_2, 8'h55);
        checkOutput("bp_valid_held", out_valid, 4'b0100);
        applyStimulus(1'b0, 2'd2, 8'h66, 4'b0000);
        #1;
        applyStimulus(1'b1, 2'd1, 8'h77, 4'b0000);
        #1;
        checkOutput("bp_resume_ready", in_ready, 1);
        step();
        checkOutput("bp_resume_out1", out_1, 8'h77);
        checkOutput("bp_resume_valid", out_valid, 4'b0110);

        // Full throughput on channel 3 with its consumer always ready.
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 2'd3, 8'(i), 4'b1000);
            #1;
            checkOutput("tput_ready", in_ready, 1);
            step();
            checkOutput("tput_out3", out_3, i);
            checkOutput("tput_v3", out_valid[3], 1);
        end

        // Fill channel 0, then drain all four channels in parallel.
        applyStimulus(1'b1, 2'd0, 8'h99, 4'b0000);
        step();
        checkOutput("pd_all_full", out_valid, 4'b1111);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);
        step();
        checkOutput("pd_all_empty", out_valid, 4'b0000);
        checkOutput("pd_out0_kept", out_0, 8'h99);
        step();
        checkOutput("pd_empty_ready", out_valid, 4'b0000);
        checkOutput("pd_out3_kept", out_3, 8'h0A);
`else
        // Round-robin dealing with select tied to 0.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 2'd0, 8'h10 + 8'(i), 4'b1111);
            #1;
            checkOutput("rr_cursel", cur_sel, i % 4);
            checkOutput("rr_ready", in_ready, 1);
            step();
            checkOutput("rr_data", chan(i % 4), 8'h10 + 8'(i));
        end
        // Pointer at 2: fill channel 2 with its consumer stalled, then go round again.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'd0, 8'h20 + 8'(i), 4'b1011);
            step();
        end
        checkOutput("rr_ch2_full", out_valid[2], 1);
        applyStimulus(1'b1, 2'd0, 8'h24, 4'b1011);
        #1;
        checkOutput("rr_stall_cursel", cur_sel, 2);
        checkOutput("rr_stall_ready", in_ready, 0);
        step();
        checkOutput("rr_stall_out2", out_2, 8'h20);
        checkOutput("rr_no_skip", cur_sel, 2);
`endif

        applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
